// File: rtl/alu_pkg.sv
// Shared ALU control codes, status bit positions and arbiter FSM states for the
// ALU arbiter slice.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_DIV  = 4'd4;
    localparam logic [3:0] ALU_MUL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_XOR  = 4'd10;
    localparam logic [3:0] ALU_NOR  = 4'd11;
    localparam logic [3:0] ALU_ADDW = 4'd12;
    localparam logic [3:0] ALU_ADDH = 4'd13;
    localparam logic [3:0] ALU_NOP  = 4'd15;

    localparam int STAT_ZERO     = 7;
    localparam int STAT_MUL_OVF  = 6;
    localparam int STAT_CARRY    = 5;
    localparam int STAT_NEG      = 4;
    localparam int STAT_MISALIGN = 3;
    localparam int STAT_DIV0     = 2;

    // Error/flag bits that accumulate in the sticky register: [6:2].
    localparam logic [7:0] STICKY_MASK = 8'h7C;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic        id;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
    } alu_op_t;

    // Counter preload for an op: EXEC lasts N cycles, so the counter starts at N-1.
    function automatic logic [3:0] exec_count(input logic [3:0] ctrl,
                                              input int unsigned mul_cycles,
                                              input int unsigned div_cycles);
        int unsigned n;
        case (ctrl)
            ALU_MUL: n = mul_cycles;
            ALU_DIV: n = div_cycles;
            default: n = 1;
        endcase
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a sole requester always wins, a tie goes to the
// current priority holder, and priority passes to the other side after each grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       id
);

    logic prio;

    always_comb begin
        id    = 1'b0;
        grant = 2'b00;
        case (valid)
            2'b01:   id = 1'b0;
            2'b10:   id = 1'b1;
            2'b11:   id = prio;
            default: id = 1'b0;
        endcase
        if (|valid) begin
            grant = id ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (advance && (|valid)) begin
            prio <= ~id;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters; holds operands for a per-op
// EXEC window and returns a registered response. Optional ALU_STICKY_STATUS_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_ctrl,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_ctrl,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic [7:0]  alu_status,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [7:0]  rsp_status,
`ifdef ALU_STICKY_STATUS_EN
    input  logic        sticky_clr,
    output logic [7:0]  sticky_status,
`endif
    output logic        busy
);

    arb_state_e  state;
    arb_state_e  next_state;
    alu_op_t     op_q;
    alu_op_t     sel_op;
    logic [3:0]  cnt;
    logic [1:0]  grant;
    logic        arb_id;
    logic        accept;
    logic        capture;
    logic        rsp_id_q;
    logic [31:0] rsp_result_q;
    logic [7:0]  rsp_status_q;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .valid   ({req1_valid, req0_valid}),
        .advance (accept),
        .grant   (grant),
        .id      (arb_id)
    );

    always_comb begin
        accept  = (state == S_IDLE) && (|grant);
        capture = (state == S_EXEC) && (cnt == 4'd0);
        if (arb_id) begin
            sel_op = '{id: 1'b1, ctrl: req1_ctrl, a: req1_a, b: req1_b};
        end else begin
            sel_op = '{id: 1'b0, ctrl: req0_ctrl, a: req0_a, b: req0_b};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept) next_state = S_EXEC;
            S_EXEC: if (cnt == 4'd0) next_state = S_RESP;
            S_RESP: if (rsp_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // ALU inputs are parked on the NOP path outside EXEC so the ALU does not toggle.
    always_comb begin
        busy       = (state != S_IDLE);
        rsp_valid  = (state == S_RESP);
        req0_ready = (state == S_IDLE) && grant[0] && !reset;
        req1_ready = (state == S_IDLE) && grant[1] && !reset;
        alu_ctrl   = ALU_NOP;
        alu_a      = 32'd0;
        alu_b      = 32'd0;
        if (state == S_EXEC) begin
            alu_ctrl = op_q.ctrl;
            alu_a    = op_q.a;
            alu_b    = op_q.b;
        end
        rsp_id     = rsp_id_q;
        rsp_result = rsp_result_q;
        rsp_status = rsp_status_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= '0;
            cnt  <= 4'd0;
        end else if (accept) begin
            op_q <= sel_op;
            cnt  <= exec_count(sel_op.ctrl, MUL_CYCLES, DIV_CYCLES);
        end else if ((state == S_EXEC) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_status_q <= 8'd0;
        end else if (capture) begin
            rsp_id_q     <= op_q.id;
            rsp_result_q <= alu_result;
            rsp_status_q <= alu_status;
        end
    end

`ifdef ALU_STICKY_STATUS_EN
    logic [7:0] sticky_q;

    // A clear in the same cycle as a capture wins, so software never sees a stale flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= 8'd0;
        end else if (sticky_clr) begin
            sticky_q <= 8'd0;
        end else if (capture) begin
            sticky_q <= sticky_q | (alu_status & STICKY_MASK);
        end
    end

    assign sticky_status = sticky_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU; covers ALU_STICKY_STATUS_EN
// when that macro is defined.
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int unsigned MUL_N = 3;
    localparam int unsigned DIV_N = 8;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    typedef struct {
        logic        id;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
        logic [7:0]  status;
        int          n;
        int          accept_edge;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [7:0]  alu_status;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_result;
    logic [7:0]  rsp_status;
`ifdef ALU_STICKY_STATUS_EN
    logic        sticky_clr;
    logic [7:0]  sticky_status;
`endif

    int   checks = 0;
    int   errors = 0;
    int   edge_count = 0;
    exp_t sb[$];
    bit   rsp_hold_low = 1'b0;
    int   rsp_ready_pct = 100;

    always #5 clk = ~clk;
    always @(posedge clk) edge_count++;

    alu_arbiter #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_status(alu_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_status(rsp_status),
`ifdef ALU_STICKY_STATUS_EN
        .sticky_clr(sticky_clr), .sticky_status(sticky_status),
`endif
        .busy(busy)
    );

    // Behavioural ALU: returns {status, result}; unused codes give 0 with only the zero flag.
    function automatic logic [39:0] alu_model(input logic [3:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] w;
        logic [32:0] s;
        logic [31:0] r;
        logic [7:0]  st;
        w = '0; s = '0; r = '0; st = '0;
        case (c)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2, 4'd12, 4'd13: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; st[5] = s[32]; end
            4'd4: if (b == 32'd0) st[2] = 1'b1; else r = a / b;
            4'd5: begin w = {32'd0, a} * {32'd0, b}; r = w[31:0]; st[6] = |w[63:32]; end
            4'd6: begin s = {1'b0, a} - {1'b0, b}; r = s[31:0]; st[5] = s[32]; end
            4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: r = a << b[4:0];
            4'd9: r = a >> b[4:0];
            4'd10: r = a ^ b;
            4'd11: r = ~(a | b);
            default: r = '0;
        endcase
        st[7] = (r == 32'd0);
        st[4] = r[31];
        return {st, r};
    endfunction

    assign {alu_status, alu_result} = alu_model(alu_ctrl, alu_a, alu_b);

    function automatic int exec_len(input logic [3:0] c);
        if (c == 4'd5) return MUL_N;
        if (c == 4'd4) return DIV_N;
        return 1;
    endfunction

    function automatic req_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        req_t r;
        r.ctrl = c; r.a = a; r.b = b;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   pick;
        pick   = $urandom_range(0, 9);
        r.ctrl = (pick < 3) ? 4'd5 : (pick < 5) ? 4'd4 : 4'($urandom_range(0, 15));
        r.a    = $urandom;
        r.b    = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
        if (r.ctrl == 4'd5 && $urandom_range(0, 1) == 1) r.b = 32'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [71:0] actual,
                               input logic [71:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: predicts grants from the round-robin rule and scores every response.
    int         model_prio = 0;
    bit         in_rsp = 1'b0;
    exp_t       held;
    logic [7:0] sticky_model = 8'd0;
    bit         prev_clr = 1'b0;

    always @(negedge clk) begin : monitor
        int   g;
        exp_t e;
        bit   cap;
        cap = 1'b0;
        if (reset) begin
            sb.delete();
            model_prio   = 0;
            in_rsp       = 1'b0;
            sticky_model = 8'd0;
            prev_clr     = 1'b0;
        end else begin
            if (!busy) begin
                g = -1;
                if (req0_valid && req1_valid) g = model_prio;
                else if (req0_valid) g = 0;
                else if (req1_valid) g = 1;
                checkOutput("req0_ready", 72'(req0_ready), 72'(g == 0));
                checkOutput("req1_ready", 72'(req1_ready), 72'(g == 1));
                checkOutput("alu_idle", 72'({alu_ctrl, alu_a, alu_b}), 72'({4'hF, 64'd0}));
                if (g >= 0) begin
                    e.id   = (g == 1);
                    e.ctrl = (g == 1) ? req1_ctrl : req0_ctrl;
                    e.a    = (g == 1) ? req1_a : req0_a;
                    e.b    = (g == 1) ? req1_b : req0_b;
                    {e.status, e.result} = alu_model(e.ctrl, e.a, e.b);
                    e.n           = exec_len(e.ctrl);
                    e.accept_edge = edge_count + 1;
                    sb.push_back(e);
                    model_prio = (g == 0) ? 1 : 0;
                end
            end else begin
                checkOutput("ready_busy", 72'({req0_ready, req1_ready}), 72'(0));
                if (!rsp_valid) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL exec_without_op busy=1 expected idle at %0t", $time);
                    end else begin
                        checkOutput("alu_hold", 72'({alu_ctrl, alu_a, alu_b}),
                                    72'({sb[0].ctrl, sb[0].a, sb[0].b}));
                    end
                end else begin
                    checkOutput("alu_idle_resp", 72'({alu_ctrl, alu_a, alu_b}), 72'({4'hF, 64'd0}));
                end
            end
            if (rsp_valid) begin
                if (!in_rsp) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpected_rsp id=%0d result=%0h expected none at %0t",
                                 rsp_id, rsp_result, $time);
                    end else begin
                        held   = sb.pop_front();
                        in_rsp = 1'b1;
                        cap    = 1'b1;
                        checkOutput("rsp_id", 72'(rsp_id), 72'(held.id));
                        checkOutput("rsp_result", 72'(rsp_result), 72'(held.result));
                        checkOutput("rsp_status", 72'(rsp_status), 72'(held.status));
                        checkOutput("rsp_latency", 72'(edge_count - held.accept_edge), 72'(held.n));
                    end
                end else begin
                    checkOutput("rsp_stable", 72'({rsp_id, rsp_result, rsp_status}),
                                72'({held.id, held.result, held.status}));
                end
                if (rsp_ready) in_rsp = 1'b0;
            end
`ifdef ALU_STICKY_STATUS_EN
            if (prev_clr) sticky_model = 8'd0;
            else if (cap) sticky_model = sticky_model | (held.status & 8'h7C);
            checkOutput("sticky_status", 72'(sticky_status), 72'(sticky_model));
            prev_clr = sticky_clr;
`endif
        end
    end

    initial begin : rsp_ready_driver
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = rsp_hold_low ? 1'b0 : ($urandom_range(0, 99) < rsp_ready_pct);
        end
    end

    task automatic waitAccept();
        bit acc0, acc1;
        int budget;
        budget = 0;
        while ((req0_valid || req1_valid) && budget < 400) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (acc0) begin
                req0_valid = 1'b0; req0_ctrl = 4'($urandom); req0_a = $urandom; req0_b = $urandom;
            end
            if (acc1) begin
                req1_valid = 1'b0; req1_ctrl = 4'($urandom); req1_a = $urandom; req1_b = $urandom;
            end
            budget++;
        end
        if (req0_valid || req1_valid) begin
            checks++; errors++;
            $display("[TB] FAIL accept_timeout valid=%b%b expected accepted", req1_valid, req0_valid);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mask, input req_t r0, input req_t r1);
        @(posedge clk);
        #1;
        req0_ctrl = r0.ctrl; req0_a = r0.a; req0_b = r0.b; req0_valid = mask[0];
        req1_ctrl = r1.ctrl; req1_a = r1.a; req1_b = r1.b; req1_valid = mask[1];
        waitAccept();
    endtask

    task automatic waitIdle();
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while ((busy || rsp_valid) && budget < 200);
        if (busy) begin
            checks++; errors++;
            $display("[TB] FAIL idle_timeout busy=%b expected 0", busy);
        end
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin : main
        int wait_budget;
        reset = 1'b1;
        req0_valid = 1'b0; req0_ctrl = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_ctrl = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
`ifdef ALU_STICKY_STATUS_EN
        sticky_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("reset_outputs",
                    72'({busy, rsp_valid, rsp_id, req0_ready, req1_ready, rsp_result, rsp_status}),
                    72'(0));
        checkOutput("reset_alu", 72'({alu_ctrl, alu_a, alu_b}), 72'({4'hF, 64'd0}));

        $display("[TB] single add, then simultaneous requests after reset");
        applyStimulus(2'b01, mk(4'd2, 32'd5, 32'd7), mk(4'd0, 32'd0, 32'd0));
        waitIdle();
        pulseReset();
        applyStimulus(2'b11, mk(4'd2, 32'd1, 32'd2), mk(4'd6, 32'd9, 32'd4));
        waitIdle();

        $display("[TB] div by zero, mul overflow, unused codes");
        applyStimulus(2'b10, mk(4'd0, 32'd0, 32'd0), mk(4'd4, 32'd100, 32'd0));
        waitIdle();
        applyStimulus(2'b01, mk(4'd5, 32'h10000, 32'h10000), mk(4'd0, 32'd0, 32'd0));
        waitIdle();
        applyStimulus(2'b10, mk(4'd0, 32'd0, 32'd0), mk(4'd3, 32'd11, 32'd22));
        waitIdle();
        applyStimulus(2'b01, mk(4'd14, 32'd33, 32'd44), mk(4'd0, 32'd0, 32'd0));
        waitIdle();

        $display("[TB] response backpressure");
        rsp_hold_low = 1'b1;
        applyStimulus(2'b01, mk(4'd10, 32'hF0F0, 32'h0FF0), mk(4'd0, 32'd0, 32'd0));
        wait_budget = 0;
        while (!rsp_valid && wait_budget < 50) begin
            @(negedge clk);
            wait_budget++;
        end
        @(posedge clk);
        #1;
        req1_ctrl = 4'd1; req1_a = 32'h1234; req1_b = 32'h8000_0000; req1_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_busy_rsp", 72'({busy, rsp_valid, req1_ready}), 72'(3'b110));
        end
        rsp_hold_low = 1'b0;
        waitAccept();
        waitIdle();

        $display("[TB] reset during div");
        applyStimulus(2'b10, mk(4'd0, 32'd0, 32'd0), mk(4'd4, 32'd1000, 32'd7));
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checkOutput("midreset_outputs",
                    72'({busy, rsp_valid, req0_ready, req1_ready, rsp_result, rsp_status}), 72'(0));
        checkOutput("midreset_alu", 72'({alu_ctrl, alu_a, alu_b}), 72'({4'hF, 64'd0}));
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (12) @(negedge clk);
        applyStimulus(2'b01, mk(4'd2, 32'd40, 32'd2), mk(4'd0, 32'd0, 32'd0));
        waitIdle();

`ifdef ALU_STICKY_STATUS_EN
        $display("[TB] sticky status");
        @(posedge clk);
        #1 sticky_clr = 1'b1;
        @(posedge clk);
        #1 sticky_clr = 1'b0;
        applyStimulus(2'b01, mk(4'd4, 32'd100, 32'd0), mk(4'd0, 32'd0, 32'd0));
        waitIdle();
        applyStimulus(2'b01, mk(4'd2, 32'd5, 32'd7), mk(4'd0, 32'd0, 32'd0));
        waitIdle();
        checkOutput("sticky_div0_add", 72'(sticky_status), 72'(8'h04));
        @(posedge clk);
        #1 sticky_clr = 1'b1;
        @(posedge clk);
        #1 sticky_clr = 1'b0;
        @(negedge clk);
        checkOutput("sticky_cleared", 72'(sticky_status), 72'(8'h00));
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 60; i++) begin
            rsp_ready_pct = (i < 30) ? 100 : 55;
            applyStimulus(2'($urandom_range(1, 3)), rand_req(), rand_req());
            if ($urandom_range(0, 1) == 1) waitIdle();
        end
        rsp_ready_pct = 100;
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 72'(sb.size()), 72'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule
